cipher_fifo_mc: RTL



---
 rtl/cipher_fifo_pkg.sv | 42 ++++
 rtl/chan_fifo.sv | 55 +++++
 rtl/cipher_fifo_mc.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cipher_fifo_pkg.sv
// Shared types and cipher round helpers for the multi-channel encrypting FIFO.
// Helpers work on a wide container and take the live width as an argument.
package cipher_fifo_pkg;

  typedef enum logic [1:0] {IDLE, ENC, DEC} state_e;

  localparam int unsigned ROT   = 3;
  localparam int unsigned MAX_W = 256;

  typedef logic [MAX_W-1:0] word_t;

  function automatic word_t width_mask(input int unsigned w);
    if (w >= MAX_W) return '1;
    return (word_t'(1) << w) - word_t'(1);
  endfunction

  function automatic word_t rotl(input word_t x, input int unsigned amt, input int unsigned w);
    int unsigned a;
    word_t       xm;
    a  = amt % w;
    xm = x & width_mask(w);
    if (a == 0) return xm;
    return ((xm << a) | (xm >> (w - a))) & width_mask(w);
  endfunction

  function automatic word_t rotr(input word_t x, input int unsigned amt, input int unsigned w);
    return rotl(x, w - (amt % w), w);
  endfunction

  function automatic word_t round_key(input word_t key, input int unsigned r, input int unsigned w);
    return (rotl(key, 8 * r, w) ^ word_t'(r)) & width_mask(w);
  endfunction

  function automatic word_t enc_round(input word_t x, input word_t k, input int unsigned w);
    return rotl(x ^ k, ROT, w);
  endfunction

  function automatic word_t dec_round(input word_t x, input word_t k, input int unsigned w);
    return (rotr(x, ROT, w) ^ k) & width_mask(w);
  endfunction

endpackage

// File: rtl/chan_fifo.sv
// Single-channel synchronous FIFO holding ciphertext words.
// DEPTH is a power of two so the pointers wrap on their own.
module chan_fifo
  import cipher_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [CNTW-1:0]   count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNTW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cipher_fifo_mc.sv
// Multi-channel encrypting FIFO: per-channel keys, one shared iterative round
// engine encrypting on write and decrypting on read, one FIFO per channel.
module cipher_fifo_mc
  import cipher_fifo_pkg::*;
#(
  parameter  int unsigned DATA_W   = 64,
  parameter  int unsigned DEPTH    = 16,
  parameter  int unsigned CHANNELS = 4,
  parameter  int unsigned ROUNDS   = 4,
  localparam int unsigned CW       = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_we,
  input  logic [CW-1:0]       key_ch,
  input  logic [DATA_W-1:0]   key_in,
  output logic                key_err,
  input  logic                wr_valid,
  input  logic [CW-1:0]       wr_ch,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                wr_ready,
  input  logic                rd_req,
  input  logic [CW-1:0]       rd_ch,
  output logic                rd_ready,
  output logic                rd_valid,
  output logic [CW-1:0]       rd_ch_o,
  output logic [DATA_W-1:0]   rd_data,
  output logic [DATA_W-1:0]   rd_cipher,
  output logic [CHANNELS-1:0] full,
  output logic [CHANNELS-1:0] empty,
  output logic                overflow
);

  localparam int unsigned RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] work_q, key_snap_q, cipher_q;
  logic [DATA_W-1:0] keys_q [CHANNELS];
  logic [DATA_W-1:0] head   [CHANNELS];
  logic [CW-1:0]     ch_q;
  logic [RW-1:0]     rnd_q;
  logic [DATA_W-1:0] rkey_c, round_out_c;
  logic              idle, rd_fire, wr_fire;
  logic              last_rnd, push_en, result_en;
  logic              key_busy, key_ok;

  // Reads win over writes when both could be taken in the same idle cycle.
  assign idle     = (state_q == IDLE);
  assign rd_ready = idle && !empty[rd_ch] && rst;
  assign wr_ready = idle && !full[wr_ch] && rst && !(rd_req && rd_ready);
  assign rd_fire  = rd_req && rd_ready;
  assign wr_fire  = wr_valid && wr_ready;

  assign rkey_c      = DATA_W'(round_key(word_t'(key_snap_q), 32'(rnd_q), DATA_W));
  assign round_out_c = (state_q == DEC)
                     ? DATA_W'(dec_round(word_t'(work_q), word_t'(rkey_c), DATA_W))
                     : DATA_W'(enc_round(word_t'(work_q), word_t'(rkey_c), DATA_W));

  // A key may only change while no word of that channel is stored or in flight.
  assign key_busy = (!idle && ch_q == key_ch) || (wr_fire && wr_ch == key_ch);
  assign key_ok   = empty[key_ch] && !key_busy;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rd_fire)      state_d = DEC;
        else if (wr_fire) state_d = ENC;
      end
      ENC:     if (last_rnd) state_d = IDLE;
      DEC:     if (last_rnd) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_rnd  = 1'b0;
    push_en   = 1'b0;
    result_en = 1'b0;
    case (state_q)
      ENC: begin
        last_rnd = (rnd_q == RW'(ROUNDS - 1));
        push_en  = last_rnd && rst;
      end
      DEC: begin
        last_rnd  = (rnd_q == '0);
        result_en = last_rnd && rst;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      work_q     <= '0;
      key_snap_q <= '0;
      cipher_q   <= '0;
      ch_q       <= '0;
      rnd_q      <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_cipher  <= '0;
      rd_ch_o    <= '0;
      key_err    <= 1'b0;
      overflow   <= 1'b0;
      for (int i = 0; i < int'(CHANNELS); i++) keys_q[i] <= '0;
    end else begin
      rd_valid <= result_en;
      key_err  <= key_we && !key_ok;
      if (idle && wr_valid && full[wr_ch]) overflow <= 1'b1;
      if (key_we && key_ok) keys_q[key_ch] <= key_in;
      if (rd_fire) begin
        work_q     <= head[rd_ch];
        cipher_q   <= head[rd_ch];
        ch_q       <= rd_ch;
        key_snap_q <= keys_q[rd_ch];
        rnd_q      <= RW'(ROUNDS - 1);
      end else if (wr_fire) begin
        work_q     <= wr_data;
        ch_q       <= wr_ch;
        key_snap_q <= keys_q[wr_ch];
        rnd_q      <= '0;
      end else if (state_q == ENC) begin
        work_q <= round_out_c;
        rnd_q  <= rnd_q + RW'(1);
      end else if (state_q == DEC) begin
        work_q <= round_out_c;
        rnd_q  <= rnd_q - RW'(1);
      end
      if (result_en) begin
        rd_data   <= round_out_c;
        rd_cipher <= cipher_q;
        rd_ch_o   <= ch_q;
      end
    end
  end

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
    chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_en && ch_q == CW'(i)),
      .push_data (round_out_c),
      .pop       (rd_fire && rd_ch == CW'(i)),
      .head      (head[i]),
      .full      (full[i]),
      .empty     (empty[i])
    );
  end

endmodule
